seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Downstream display stage for the BCD counter. It takes four packed BCD digits and drives the board's 4-digit common-anode 7-segment display by time-multiplexing. Both anodes and cathodes are active-low. It adds anti-ghosting blank time, frame-synchronous input snapshotting, leading-zero blanking and per-digit decimal points.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= BLANK_CYC+2
BLANK_CYC, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); may be 0

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low (0 = reset)
en  in  1  display enable; 0 forces all outputs off
digits  in  16  BCD digits; [3:0] = digit0 (rightmost, an[0]) ... [15:12] = digit3
dp_in  in  4  decimal point request per digit, active-high; bit i = digit i
blank_lz  in  1  1 = blank leading zeros
an  out  4  anode enables, active-low
seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point cathode, active-low
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (rst=0, async): cnt=0, idx=0, shadow digits/dp/blank_lz=0, an=4'hF, seg=7'h7F, dp=1, frame_tick=0.
- cnt counts 0..SCAN_DIV-1, then wraps to 0.
- On each cnt wrap, idx advances 0→1→2→3→0.
- Frame start is the edge where cnt wraps with idx==3:
  - idx becomes 0.
  - shadow registers load digits, dp_in and blank_lz.
  - frame_tick=1 for exactly that one cycle.
- Frame length is 4*SCAN_DIV cycles. The first frame after reset shows shadow=0.
- The display uses only shadow values. Input changes mid-frame are invisible until the next frame start (no tearing).
- an, seg, dp and frame_tick are registered. They are computed from the next-state cnt/idx/shadow, so they align exactly with the registered cnt/idx (no extra lag).
- Within a slot (current digit = idx):
  - cnt < BLANK_CYC: an=4'hF, seg=7'h7F, dp=1.
  - cnt >= BLANK_CYC: an[idx]=0 and the others 1; seg=decode(shadow digit idx); dp=~shadow_dp[idx].
- Decode (active-low {g..a}):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000
  - codes 10–15: dash 0111111
- Leading-zero blanking (shadow blank_lz=1):
  - Digit i (i=3,2,1) is blanked when it and every higher digit equal 0. Digit0 is never blanked.
  - A blanked digit keeps an=1 and seg=7'h7F for its whole slot.
  - A blanked digit's dp is also off, unless its shadow dp bit is set, in which case the digit is not blanked.
- en=0: an=4'hF, seg=7'h7F, dp=1. cnt, idx, snapshot and frame_tick keep running. Re-enable takes effect on the next cycle with no resync.
- Reset asserted mid-slot: outputs go off immediately. Scanning restarts at idx=0, cnt=0 on release.
- Widths: cnt width = $clog2(SCAN_DIV); idx is 2 bits and wraps naturally.

Decomposition:
- Shared package seg7_pkg:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (7'h7F)
  - AN_OFF (4'hF)
- One natural sub-module: bcd_to_seg7 (combinational 4-bit→7-bit active-low decoder, dash for 10–15). The BCD counter may reuse it.

Test Plan:
Bench uses SCAN_DIV=8, BLANK_CYC=2, frame = 32 cycles.
- Async reset: drive rst=0 mid-slot, between clock edges → an=F, seg=7F, dp=1 immediately; after release, first frame_tick occurs 32 cycles later.
- digits=16'h1234, blank_lz=0, dp_in=0, en=1, after one frame_tick:
  - slot0: an=F for 2 cycles, then an=1110, seg=0011001 (4) for 6 cycles.
  - slot1: an=1101, seg=0110000 (3).
  - slot2: an=1011, seg=0100100 (2).
  - slot3: an=0111, seg=1111001 (1).
- blank_lz=1:
  - digits=16'h0050 → an[3], an[2] never 0; slot1 seg=0010010; slot0 seg=1000000.
  - digits=16'h0000 → only an[0] ever asserts.
  - dp_in=4'b0100 with 16'h0000 → digit2 shows 1000000 with dp=0.
- Snapshot: set 16'h1111, then change to 16'h9999 at cycle 10 of a frame → seg=1111001 for the rest of that frame; 0010000 only after the next frame_tick. frame_tick period = 32 cycles.
- digits=16'h00AF, blank_lz=0 → slots 0 and 1 show 0111111; slots 2 and 3 show 1000000.
- en=0 for one full frame → an=F, seg=7F, dp=1 throughout while frame_tick still pulses every 32 cycles; en=1 → normal output from the next cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low segment and anode constants for the 7-segment display path
package seg7_pkg;
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] AN_OFF   = 4'hF;
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display data in and multiplexed anode/cathode drive out
interface seg7_scan_driver_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  modport master (output en, digits, dp_in, blank_lz, input an, seg, dp, frame_tick);
  modport slave  (input en, digits, dp_in, blank_lz, output an, seg, dp, frame_tick);
endinterface

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: 4-bit BCD to active-low {g..a} segments, dash for codes 10-15
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode scan with blank time, frame snapshot, zero blanking
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   sh_d, sh_d_nxt;
  logic [3:0]    sh_dp, sh_dp_nxt;
  logic          sh_lz, sh_lz_nxt;
  logic          wrap, frame, lit_cnt, on;
  logic [3:0]    lz, cur;
  logic [6:0]    cur_seg;
  if (BLANK_CYC == 0) begin : g_no_blank
    assign lit_cnt = 1'b1;
  end else begin : g_blank
    assign lit_cnt = cnt_nxt >= CW'(BLANK_CYC);
  end
  // outputs are derived from next-state values so they line up with the registered cnt/idx
  always_comb begin
    wrap      = cnt == LAST;
    frame     = wrap && idx == 2'd3;
    cnt_nxt   = wrap ? '0 : cnt + 1'b1;
    idx_nxt   = wrap ? idx + 2'd1 : idx;
    sh_d_nxt  = frame ? bus.digits : sh_d;
    sh_dp_nxt = frame ? bus.dp_in : sh_dp;
    sh_lz_nxt = frame ? bus.blank_lz : sh_lz;
    lz        = '0;
    lz[3]     = sh_d_nxt[15:12] == 4'd0;
    lz[2]     = lz[3] && sh_d_nxt[11:8] == 4'd0;
    lz[1]     = lz[2] && sh_d_nxt[7:4] == 4'd0;
    cur       = sh_d_nxt[{idx_nxt, 2'b00} +: 4];
    on        = bus.en && lit_cnt && !(sh_lz_nxt && lz[idx_nxt] && !sh_dp_nxt[idx_nxt]);
  end
  bcd_to_seg7 u_dec (.bcd(cur), .seg(cur_seg));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      idx            <= '0;
      sh_d           <= '0;
      sh_dp          <= '0;
      sh_lz          <= 1'b0;
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.dp         <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      idx            <= idx_nxt;
      sh_d           <= sh_d_nxt;
      sh_dp          <= sh_dp_nxt;
      sh_lz          <= sh_lz_nxt;
      bus.an         <= on ? ~(4'b0001 << idx_nxt) : AN_OFF;
      bus.seg        <= on ? cur_seg : SEG_OFF;
      bus.dp         <= on ? ~sh_dp_nxt[idx_nxt] : 1'b1;
      bus.frame_tick <= frame;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: frame-level expectations queued by stimulus, checked per cycle by a monitor
module tb_seg7_scan_driver;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S9 = 7'b0010000, SD = 7'b0111111;
  localparam logic [6:0] OFF = 7'h7F;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       care;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t e;
  seg7_scan_driver_if bus ();
  seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: an/seg/dp/ft got %b required %b", nm, $time, act, req);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (rst && q.size() > 0) begin
      e = q.pop_front();
      if (e.care) chk("scan", {bus.an, bus.seg, bus.dp, bus.frame_tick}, {e.an, e.seg, e.dp, e.ft});
    end
  end
  task automatic play(input logic [3:0][6:0] s, input logic [3:0] lit, input logic [3:0] dpe,
                      input logic en_e, input int start, input logic [3:0] care,
                      input int chg_at, input logic [15:0] chg_d);
    exp_t x;
    int   sl;
    logic on;
    for (int c = start; c < 32; c++) begin
      sl     = c / 8;
      on     = en_e && (c % 8) >= 2 && lit[sl];
      x.an   = on ? ~(4'b0001 << sl) : 4'hF;
      x.seg  = on ? s[sl] : OFF;
      x.dp   = on ? ~dpe[sl] : 1'b1;
      x.ft   = c == 0;
      x.care = care[sl];
      q.push_back(x);
    end
    for (int c = start; c < 32; c++) begin
      @(posedge clk);
      if (c == chg_at) begin
        #2 bus.digits = chg_d;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.en = 1'b1;
    bus.digits = 16'h0000;
    bus.dp_in = 4'b0000;
    bus.blank_lz = 1'b0;
    #1 rst = 1'b0;
    #2 chk("reset_state", {bus.an, bus.seg, bus.dp, bus.frame_tick}, {4'hF, OFF, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    #1 chk("reset_hold", {bus.an, bus.seg, bus.dp, bus.frame_tick}, {4'hF, OFF, 1'b1, 1'b0});
    @(negedge clk) rst = 1'b1;
    play({S0, S0, S0, S0}, 4'hF, 4'h0, 1'b1, 1, 4'hF, -1, 16'h0);
    bus.digits = 16'h1234;
    play({S1, S2, S3, S4}, 4'hF, 4'h0, 1'b1, 0, 4'hF, -1, 16'h0);
    bus.digits = 16'h0050;
    bus.blank_lz = 1'b1;
    play({S0, S0, S5, S0}, 4'b0011, 4'h0, 1'b1, 0, 4'hF, -1, 16'h0);
    bus.digits = 16'h0000;
    play({S0, S0, S0, S0}, 4'b0001, 4'h0, 1'b1, 0, 4'hF, -1, 16'h0);
    bus.dp_in = 4'b0100;
    play({S0, S0, S0, S0}, 4'b0101, 4'b0100, 1'b1, 0, 4'b1101, -1, 16'h0);
    bus.dp_in = 4'b0000;
    bus.blank_lz = 1'b0;
    bus.digits = 16'h1111;
    play({S1, S1, S1, S1}, 4'hF, 4'h0, 1'b1, 0, 4'hF, 10, 16'h9999);
    play({S9, S9, S9, S9}, 4'hF, 4'h0, 1'b1, 0, 4'hF, -1, 16'h0);
    bus.digits = 16'h00AF;
    play({S0, S0, SD, SD}, 4'hF, 4'h0, 1'b1, 0, 4'hF, -1, 16'h0);
    bus.digits = 16'h1234;
    bus.en = 1'b0;
    play({S1, S2, S3, S4}, 4'hF, 4'h0, 1'b0, 0, 4'hF, -1, 16'h0);
    bus.en = 1'b1;
    play({S1, S2, S3, S4}, 4'hF, 4'h0, 1'b1, 0, 4'hF, -1, 16'h0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("async_reset", {bus.an, bus.seg, bus.dp, bus.frame_tick}, {4'hF, OFF, 1'b1, 1'b0});
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    play({S0, S0, S0, S0}, 4'hF, 4'h0, 1'b1, 1, 4'hF, -1, 16'h0);
    play({S1, S2, S3, S4}, 4'hF, 4'h0, 1'b1, 0, 4'hF, -1, 16'h0);
    chk("queue_drained", 13'(q.size()), 13'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
